// File: rtl/softmax_row_scheduler_if.sv
// Requester-side and response-side handshake bundle for softmax_row_scheduler.
// The scheduler uses the slave modport; the requester/consumer side uses master.
interface softmax_row_scheduler_if #(
    parameter int NREQ = 4,
    parameter int ID_W = 2
);
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*128-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [ID_W-1:0]     rsp_id;
    logic [127:0]        rsp_data;
    logic                rsp_err;

    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
    );
endinterface

// File: rtl/softmax_row_scheduler.sv
// Round-robin sharing of one 4-element softmax engine among NREQ requesters:
// grant, Start pulse, four serial Datain words, Done/timeout wait, tagged response.
module softmax_row_scheduler #(
    parameter int NREQ    = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    softmax_row_scheduler_if.slave bus,
    output logic                   sm_start,
    output logic [31:0]            sm_din,
    output logic [2:0]             sm_n,
    input  logic [127:0]           sm_y,
    input  logic                   sm_done,
    output logic                   busy,
    output logic                   err_timeout
);
    typedef enum logic [2:0] {IDLE, PULSE, FEED0, FEED1, FEED2, FEED3, WAIT, RESP} state_t;

    state_t          state, state_nxt;
    logic [ID_W-1:0] rr_ptr, cur_id, win_id;
    logic            win_found, take, to_hit;
    logic [ID_W:0]   scan;
    logic [127:0]    row_buf, rsp_data_q;
    logic            rsp_err_q;
    logic [TO_W-1:0] to_cnt;

    // Search from rr_ptr upward, wrapping, for the first requester with a row.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        scan      = '0;
        for (int i = 0; i < NREQ; i++) begin
            scan = {1'b0, rr_ptr} + (ID_W+1)'(i);
            if (scan >= (ID_W+1)'(NREQ)) scan = scan - (ID_W+1)'(NREQ);
            if (!win_found && bus.req_valid[scan[ID_W-1:0]]) begin
                win_found = 1'b1;
                win_id    = scan[ID_W-1:0];
            end
        end
    end

    assign take   = (state == IDLE) && win_found;
    assign to_hit = (to_cnt == TO_W'(TIMEOUT - 1));

    // req_ready is gated by rst so the strobe stays low while reset is held.
    always_comb begin
        bus.req_ready = '0;
        if (take && rst) bus.req_ready[win_id] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        sm_start  = 1'b0;
        sm_din    = '0;
        unique case (state)
            IDLE:  if (win_found) state_nxt = PULSE;
            PULSE: begin
                sm_start  = 1'b1;
                sm_din    = row_buf[31:0];
                state_nxt = FEED0;
            end
            FEED0: begin
                sm_din    = row_buf[31:0];
                state_nxt = FEED1;
            end
            FEED1: begin
                sm_din    = row_buf[63:32];
                state_nxt = FEED2;
            end
            FEED2: begin
                sm_din    = row_buf[95:64];
                state_nxt = FEED3;
            end
            FEED3: begin
                sm_din    = row_buf[127:96];
                state_nxt = WAIT;
            end
            WAIT:  if (sm_done || to_hit) state_nxt = RESP;
            RESP:  if (bus.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            cur_id      <= '0;
            to_cnt      <= '0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (take) begin
                cur_id <= win_id;
                rr_ptr <= (win_id == ID_W'(NREQ - 1)) ? '0 : win_id + 1'b1;
            end
            if (state == FEED3)     to_cnt <= '0;
            else if (state == WAIT) to_cnt <= to_cnt + 1'b1;
            // Done takes priority over a timeout landing on the same cycle.
            if (state == WAIT) begin
                if (sm_done) begin
                    rsp_data_q <= sm_y;
                    rsp_err_q  <= 1'b0;
                end else if (to_hit) begin
                    rsp_data_q  <= '0;
                    rsp_err_q   <= 1'b1;
                    err_timeout <= 1'b1;
                end
            end
        end
    end

    // Row snapshot: later req_data changes cannot reach the job in flight.
    always_ff @(posedge clk) begin
        if (take) row_buf <= bus.req_data[128*win_id +: 128];
    end

    assign sm_n          = 3'd3;
    assign busy          = (state != IDLE);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_id    = cur_id;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_softmax_row_scheduler.sv
// Randomized bench for softmax_row_scheduler with a behavioural engine and arbiter model.
module tb_softmax_row_scheduler;
    localparam int NREQ    = 4;
    localparam int ID_W    = 2;
    localparam int TIMEOUT = 255;
    localparam int TO_W    = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    softmax_row_scheduler_if #(.NREQ(NREQ), .ID_W(ID_W)) bus ();

    logic         sm_start;
    logic [31:0]  sm_din;
    logic [2:0]   sm_n;
    logic [127:0] sm_y;
    logic         sm_done;
    logic         busy;
    logic         err_timeout;

    softmax_row_scheduler #(.NREQ(NREQ), .ID_W(ID_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .sm_start(sm_start), .sm_din(sm_din), .sm_n(sm_n), .sm_y(sm_y),
        .sm_done(sm_done), .busy(busy), .err_timeout(err_timeout)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [127:0]    row [NREQ];
    logic [NREQ-1:0] pending;
    bit              refill;
    int              exp_ptr;

    bit              obs_granted;
    logic [NREQ-1:0] obs_ready;
    int              obs_gid;
    int              obs_starts;
    bit              obs_start_first;
    logic [31:0]     obs_din [5];
    int              obs_wait;
    bit              obs_valid;
    logic [ID_W-1:0] obs_id;
    logic [127:0]    obs_data;
    logic            obs_err, obs_errto;
    bit              obs_stable, obs_drop;
    logic [170:0]    obs_rst_outs;

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Arbiter reference: first pending requester at or after ptr, modulo NREQ.
    function automatic int exp_winner(input logic [NREQ-1:0] p, input int ptr);
        for (int i = 0; i < NREQ; i++)
            if (p[(ptr + i) % NREQ]) return (ptr + i) % NREQ;
        return -1;
    endfunction

    task automatic drive_reqs();
        bus.req_valid = pending;
        for (int i = 0; i < NREQ; i++) bus.req_data[128*i +: 128] = row[i];
    endtask

    // Runs one job from a negedge in IDLE, playing requester, engine and consumer.
    task automatic run_job(input int lat, input bit mute, input bit stray,
                           input int hold, input int abort_at);
        logic [127:0] y;
        int c;
        obs_granted = 0; obs_gid = -1; obs_ready = '0; obs_starts = 0;
        obs_start_first = 0; obs_wait = 0; obs_valid = 0; obs_stable = 1; obs_drop = 0;
        obs_rst_outs = '1;
        for (int t = 0; t < 8 && !obs_granted; t++) begin
            #1;
            if (bus.req_ready !== '0) begin
                obs_granted = 1;
                obs_ready   = bus.req_ready;
                for (int i = NREQ - 1; i >= 0; i--) if (bus.req_ready[i]) obs_gid = i;
            end else begin
                @(negedge clk);
            end
        end
        if (!obs_granted) return;
        @(negedge clk);
        row[obs_gid]     = rand128();
        pending[obs_gid] = refill;
        drive_reqs();
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            obs_starts += int'(sm_start);
            if (k == 0) obs_start_first = sm_start;
            obs_din[k] = sm_din;
            sm_done = stray && (k == 2);
            sm_y    = rand128();
        end
        sm_done = 0;
        y = {~obs_din[4], ~obs_din[3], ~obs_din[2], ~obs_din[1]};
        c = 0;
        for (int t = 0; t < TIMEOUT + 10; t++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                obs_valid = 1;
                break;
            end
            if (c == abort_at) begin
                rst = 0;
                #1;
                obs_rst_outs = {bus.req_ready, sm_start, sm_din, bus.rsp_valid, bus.rsp_id,
                                bus.rsp_data, bus.rsp_err, busy, err_timeout};
                @(negedge clk);
                rst = 1;
                sm_done = 0;
                obs_wait = c;
                return;
            end
            sm_done = !mute && (c == lat);
            sm_y    = sm_done ? y : rand128();
            c++;
        end
        obs_wait = c;
        sm_done  = 0;
        if (!obs_valid) return;
        obs_id    = bus.rsp_id;
        obs_data  = bus.rsp_data;
        obs_err   = bus.rsp_err;
        obs_errto = err_timeout;
        for (int h = 0; h < hold; h++) begin
            sm_done = ($urandom_range(0, 1) == 1);
            sm_y    = rand128();
            @(negedge clk);
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== obs_data || bus.rsp_err !== obs_err ||
                bus.rsp_id !== obs_id || bus.req_ready !== '0) obs_stable = 0;
        end
        sm_done = 0;
        bus.rsp_ready = 1;
        @(negedge clk);
        obs_drop = (bus.rsp_valid === 1'b0);
        bus.rsp_ready = 0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < NREQ; i++) row[i] = rand128();
        pending = '1;
        drive_reqs();
        rst = 0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (bus.req_ready !== '0) begin
            n_fail++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready);
        end
        n_checks++;
        if ({sm_start, sm_din} !== 33'd0) begin
            n_fail++; $display("FAIL reset_engine: start %b din %h want 0", sm_start, sm_din);
        end
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err} !== '0) begin
            n_fail++; $display("FAIL reset_rsp: valid %b id %0d data %h err %b want 0",
                               bus.rsp_valid, bus.rsp_id, bus.rsp_data, bus.rsp_err);
        end
        n_checks++;
        if ({busy, err_timeout} !== 2'b00) begin
            n_fail++; $display("FAIL reset_status: busy %b err_timeout %b want 0", busy, err_timeout);
        end
        pending = '0;
        drive_reqs();
        rst = 1;
        exp_ptr = 0;
        @(negedge clk);
    endtask

    task automatic test_single();
        logic [127:0] exp_row;
        logic [31:0]  exp_din [5];
        int w;
        row[0] = {32'h40800000, 32'h40400000, 32'h40000000, 32'h3F800000};
        pending = 4'b0001; refill = 0; drive_reqs();
        exp_row = row[0];
        exp_din = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        w = exp_winner(pending, exp_ptr);
        run_job(3, 0, 0, 0, -1);
        exp_ptr = (w + 1) % NREQ;
        n_checks++;
        if (obs_ready !== 4'b0001) begin
            n_fail++; $display("FAIL single_grant: req_ready %b want 0001", obs_ready);
        end
        n_checks++;
        if (obs_starts != 1 || !obs_start_first) begin
            n_fail++; $display("FAIL single_start: %0d pulses (first %b) want 1 in first cycle",
                               obs_starts, obs_start_first);
        end
        for (int k = 0; k < 5; k++) begin
            n_checks++;
            if (obs_din[k] !== exp_din[k]) begin
                n_fail++; $display("FAIL single_din%0d: got %h want %h", k, obs_din[k], exp_din[k]);
            end
        end
        n_checks++;
        if (obs_wait != 4) begin
            n_fail++; $display("FAIL single_wait: %0d WAIT cycles want 4", obs_wait);
        end
        n_checks++;
        if (!obs_valid || obs_id !== 2'd0 || obs_data !== ~exp_row || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL single_rsp: valid %b id %0d data %h err %b want id 0 data %h err 0",
                               obs_valid, obs_id, obs_data, obs_err, ~exp_row);
        end
        n_checks++;
        if (!obs_drop || sm_n !== 3'd3) begin
            n_fail++; $display("FAIL single_done: valid dropped %b sm_n %0d want 1 and 3", obs_drop, sm_n);
        end
    endtask

    task automatic test_fairness();
        logic [127:0] exp_row;
        int w;
        for (int i = 0; i < NREQ; i++) row[i] = rand128();
        pending = '1; refill = 1; drive_reqs();
        for (int j = 0; j < 8; j++) begin
            w = exp_winner(pending, exp_ptr);
            exp_row = row[w];
            run_job($urandom_range(0, 5), 0, ($urandom_range(0, 1) == 1), $urandom_range(0, 2), -1);
            exp_ptr = (w + 1) % NREQ;
            n_checks++;
            if (obs_gid != w) begin
                n_fail++; $display("FAIL fair_grant%0d: granted %0d want %0d", j, obs_gid, w);
            end
            n_checks++;
            if (!obs_valid || obs_id !== ID_W'(w) || obs_data !== ~exp_row || obs_err !== 1'b0) begin
                n_fail++; $display("FAIL fair_rsp%0d: valid %b id %0d data %h err %b want id %0d data %h",
                                   j, obs_valid, obs_id, obs_data, obs_err, w, ~exp_row);
            end
        end
        pending = '0; refill = 0; drive_reqs();
    endtask

    task automatic test_backpressure();
        logic [127:0] exp_row;
        int w;
        row[2] = rand128();
        pending = 4'b0100; drive_reqs();
        w = exp_winner(pending, exp_ptr);
        exp_row = row[2];
        run_job(1, 0, 0, 10, -1);
        exp_ptr = (w + 1) % NREQ;
        n_checks++;
        if (!obs_stable) begin
            n_fail++; $display("FAIL bp_stable: response moved or req_ready rose under rsp_ready=0 (data %h)", obs_data);
        end
        n_checks++;
        if (!obs_valid || obs_id !== 2'd2 || obs_data !== ~exp_row) begin
            n_fail++; $display("FAIL bp_rsp: id %0d data %h want id 2 data %h", obs_id, obs_data, ~exp_row);
        end
        n_checks++;
        if (!obs_drop) begin
            n_fail++; $display("FAIL bp_drop: rsp_valid %b after accept want 0", bus.rsp_valid);
        end
    endtask

    task automatic test_timeout();
        logic [127:0] exp_row;
        int w;
        row[3] = rand128();
        pending = 4'b1000; drive_reqs();
        w = exp_winner(pending, exp_ptr);
        run_job(0, 1, 0, 2, -1);
        exp_ptr = (w + 1) % NREQ;
        n_checks++;
        if (obs_wait != TIMEOUT) begin
            n_fail++; $display("FAIL to_wait: %0d WAIT cycles want %0d", obs_wait, TIMEOUT);
        end
        n_checks++;
        if (!obs_valid || obs_id !== 2'd3 || obs_data !== '0 || obs_err !== 1'b1 || obs_errto !== 1'b1) begin
            n_fail++; $display("FAIL to_rsp: id %0d data %h err %b sticky %b want id 3 data 0 err 1 sticky 1",
                               obs_id, obs_data, obs_err, obs_errto);
        end
        row[0] = rand128();
        pending = 4'b0001; drive_reqs();
        w = exp_winner(pending, exp_ptr);
        exp_row = row[0];
        run_job(2, 0, 1, 0, -1);
        exp_ptr = (w + 1) % NREQ;
        n_checks++;
        if (!obs_valid || obs_id !== 2'd0 || obs_data !== ~exp_row || obs_err !== 1'b0 || obs_wait != 3) begin
            n_fail++; $display("FAIL to_next: id %0d data %h err %b wait %0d want id 0 data %h err 0 wait 3",
                               obs_id, obs_data, obs_err, obs_wait, ~exp_row);
        end
        n_checks++;
        if (err_timeout !== 1'b1) begin
            n_fail++; $display("FAIL to_sticky: err_timeout %b want 1", err_timeout);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [127:0] exp_row;
        row[2] = rand128();
        pending = 4'b0100; refill = 0; drive_reqs();
        run_job(0, 1, 0, 0, 5);
        exp_ptr = 0;
        n_checks++;
        if (obs_rst_outs !== '0) begin
            n_fail++; $display("FAIL rst_outs: outputs %h during reset want 0", obs_rst_outs);
        end
        for (int t = 0; t < 3; t++) begin
            n_checks++;
            if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
                n_fail++; $display("FAIL rst_idle%0d: rsp_valid %b busy %b want 0", t, bus.rsp_valid, busy);
            end
            @(negedge clk);
        end
        for (int i = 0; i < NREQ; i++) row[i] = rand128();
        pending = '1; drive_reqs();
        exp_row = row[0];
        run_job(0, 0, 0, 0, -1);
        exp_ptr = 1;
        pending = '0; drive_reqs();
        n_checks++;
        if (obs_gid != 0 || obs_data !== ~exp_row || obs_id !== 2'd0) begin
            n_fail++; $display("FAIL rst_first_grant: granted %0d id %0d data %h want 0 and %h",
                               obs_gid, obs_id, obs_data, ~exp_row);
        end
    endtask

    task automatic test_tie();
        logic [127:0] exp_row;
        int w;
        rst = 0;
        @(negedge clk);
        rst = 1;
        exp_ptr = 0;
        row[1] = rand128();
        pending = 4'b0010; drive_reqs();
        w = exp_winner(pending, exp_ptr);
        exp_row = row[1];
        run_job(TIMEOUT - 1, 0, 0, 0, -1);
        exp_ptr = (w + 1) % NREQ;
        n_checks++;
        if (!obs_valid || obs_wait != TIMEOUT || obs_id !== 2'd1 || obs_data !== ~exp_row || obs_err !== 1'b0) begin
            n_fail++; $display("FAIL tie_rsp: wait %0d id %0d data %h err %b want wait %0d id 1 data %h err 0",
                               obs_wait, obs_id, obs_data, obs_err, TIMEOUT, ~exp_row);
        end
        n_checks++;
        if (obs_errto !== 1'b0 || err_timeout !== 1'b0) begin
            n_fail++; $display("FAIL tie_sticky: err_timeout %b/%b want 0", obs_errto, err_timeout);
        end
    endtask

    initial begin
        bus.rsp_ready = 0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        sm_done = 0;
        sm_y    = '0;
        refill  = 0;
        exp_ptr = 0;
        @(negedge clk);
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_tie();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/softmax_row_scheduler.md
Name: softmax_row_scheduler

Overview:
- Shares one row-wise softmax engine (4-element FP32 rows, N=3) between NREQ requesters, for example attention heads.
- Arbitrates round-robin, latches the granted row, and sequences the engine: a one-cycle Start pulse followed by four serial Datain words.
- Waits for Done with a timeout guard, then returns the four results tagged with the requester ID over a valid/ready response port.

Parameters:
- NREQ, 4, number of requesters (2..8).
- ID_W, 2, requester ID width; must equal clog2(NREQ).
- TIMEOUT, 255, maximum cycles spent in WAIT before the job aborts.
- TO_W, 8, timeout counter width; must satisfy 2^TO_W > TIMEOUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  per-requester row-available flag.
- req_data  in  NREQ*128  per-requester row; requester i occupies bits [128i+127:128i]; word k occupies bits [32k+31:32k] of that slice.
- req_ready  out  NREQ  one-hot accept strobe.
- sm_start  out  1  engine Start.
- sm_din  out  32  engine Datain.
- sm_n  out  3  engine N; constant 3'd3.
- sm_y  in  128  engine Y3..Y0; Yk occupies bits [32k+31:32k].
- sm_done  in  1  engine Done.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  ID of the requester that owns the response.
- rsp_data  out  128  softmax results, same packing as sm_y.
- rsp_err  out  1  response was aborted by timeout.
- busy  out  1  state is not IDLE.
- err_timeout  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset (rst=0, asynchronous) drives all outputs to 0: rsp_*, sm_start, sm_din, req_ready, busy, err_timeout. It also sets state=IDLE and rr_ptr=0.
- Reset mid-job abandons the job; no response is produced.
- States: IDLE, PULSE, FEED0, FEED1, FEED2, FEED3, WAIT, RESP.
- IDLE:
  - Winner g is the first index with req_valid=1, searching from rr_ptr upward and wrapping modulo NREQ.
  - req_ready[g]=1 combinationally; all other bits are 0. req_ready is 0 in every other state.
  - On the handshake: latch req_data slice g into row_buf, set cur_id=g, set rr_ptr=(g+1) mod NREQ, go to PULSE.
  - With no req_valid, stay in IDLE.
- PULSE: sm_start=1 for exactly one cycle; sm_din=row_buf word0; go to FEED0.
- FEEDk (k=0..3): sm_din=row_buf word k, sm_start=0. FEEDk goes to FEED(k+1); FEED3 goes to WAIT.
- sm_din is 0 outside PULSE and FEED states.
- WAIT:
  - to_cnt is cleared on entry and increments each cycle.
  - If sm_done=1: latch sm_y into rsp_data, set rsp_err=0, go to RESP.
  - Else if to_cnt==TIMEOUT-1: set rsp_data=0, rsp_err=1, err_timeout=1, go to RESP.
  - If sm_done=1 on the timeout cycle, Done wins.
- sm_done outside WAIT is ignored. A late Done after a timeout must not corrupt the next job.
- RESP:
  - rsp_valid=1, rsp_id=cur_id.
  - rsp_data and rsp_err stay stable until rsp_ready=1.
  - rsp_ready=1 while rsp_valid=1 completes the transfer: rsp_valid drops the next cycle, state returns to IDLE.
  - The next grant can occur in that IDLE cycle.
- Latency: grant to sm_start is 1 cycle. Minimum grant to rsp_valid is 6 + engine Done latency, counted in cycles after FEED3.
- Single job in flight; no request queueing. Requesters hold req_valid and req_data until their ready strobe.
- Changes to req_data after the handshake have no effect on the job in progress.

Test Plan:
- Single request: req_valid=0001 with row {1.0,2.0,3.0,4.0}, engine model → sm_start once; sm_din sequence 3F800000, 3F800000, 40000000, 40400000, 40800000; rsp_id=0; rsp_data equals the model output; rsp_err=0.
- Fairness: all four req_valid held high for 8 jobs → grant order 0,1,2,3,0,1,2,3; every rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 10 cycles in RESP → rsp_valid and rsp_data stable, req_ready stays 0; rsp_ready=1 → rsp_valid falls the next cycle.
- Timeout: engine model never asserts Done → after TIMEOUT cycles in WAIT, rsp_err=1, rsp_data=0, err_timeout=1 (stays 1). The next job then completes normally even when a stray Done arrives during its FEED states.
- Timeout/Done tie: Done asserted exactly on cycle TIMEOUT-1 → normal response, err_timeout stays 0.
- Reset mid-WAIT: rst=0 for 1 cycle → all outputs 0 and busy=0 immediately. After rst release, requester 0 wins the first grant.
